// File: rtl/fp_stim_pkg.sv
// fp_stim_pkg
// Shared definitions for the floating-point stimulus sequencer:
//   - fp_class_t   : operand class codes (12 classes, 12-15 fold to +zero)
//   - stim_mode_t  : run modes (random, class sweep, single class pair)
//   - seq_state_t  : sequencer FSM states
//   - LFSR_POLY    : Galois feedback mask for x^64+x^63+x^61+x^60+1
//   - NUM_CLASSES  : number of legal class codes
//   - lfsr_step()  : one Galois LFSR step
//   - cls_clamp()  : folds out-of-range class codes to 0
package fp_stim_pkg;

   typedef enum logic [3:0] {
      CLS_PZERO = 4'd0,
      CLS_NZERO = 4'd1,
      CLS_PINF  = 4'd2,
      CLS_NINF  = 4'd3,
      CLS_PSNAN = 4'd4,
      CLS_NSNAN = 4'd5,
      CLS_PQNAN = 4'd6,
      CLS_NQNAN = 4'd7,
      CLS_PNORM = 4'd8,
      CLS_NNORM = 4'd9,
      CLS_PDEN  = 4'd10,
      CLS_NDEN  = 4'd11
   } fp_class_t;

   typedef enum logic [1:0] {
      MODE_RANDOM = 2'b00,
      MODE_SWEEP  = 2'b01,
      MODE_SINGLE = 2'b10
   } stim_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   // Right-shifting Galois form: taps 64,63,61,60 land on bits 63,62,60,59.
   localparam logic [63:0] LFSR_POLY   = 64'hD800_0000_0000_0000;
   localparam logic [3:0]  NUM_CLASSES = 4'd12;

   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
   endfunction

   function automatic logic [3:0] cls_clamp(input logic [3:0] c);
      return (c >= NUM_CLASSES) ? 4'd0 : c;
   endfunction

endpackage

// File: rtl/fp_stim_seq_enc.sv
// fp_class_encoder
// Combinational builder of one IEEE-style operand of a requested class.
//   cls : class code (12-15 treated as +zero)
//   r   : random word; exponent taken from r[MAN_W +: EXP_W], mantissa
//         from r[MAN_W-1:0]
//   op  : {sign, exponent, mantissa}, W = 1+EXP_W+MAN_W bits
module fp_class_encoder
   import fp_stim_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [3:0]             cls,
   input  logic [EXP_W+MAN_W-1:0] r,
   output logic [EXP_W+MAN_W:0]   op
);

   logic [3:0]       c;
   logic [EXP_W-1:0] exp_r;
   logic [EXP_W-1:0] e;
   logic [MAN_W-1:0] man_r;
   logic [MAN_W-1:0] m;
   logic [MAN_W-2:0] payload;

   always_comb begin
      c     = cls_clamp(cls);
      exp_r = r[MAN_W +: EXP_W];
      man_r = r[MAN_W-1:0];
      // NaN payload below the quiet bit must be nonzero, or sNaN would read as inf.
      payload = man_r[MAN_W-2:0];
      if (payload == '0) payload[0] = 1'b1;
      e = '0;
      m = '0;
      case (c)
         CLS_PINF, CLS_NINF: e = '1;
         CLS_PSNAN, CLS_NSNAN: begin
            e = '1;
            m = {1'b0, payload};
         end
         CLS_PQNAN, CLS_NQNAN: begin
            e = '1;
            m = {1'b1, payload};
         end
         CLS_PNORM, CLS_NNORM: begin
            // Keep the exponent strictly inside the normal range.
            e = exp_r;
            if (e == '0)      e    = EXP_W'(1);
            else if (e == '1) e[0] = 1'b0;
            m = man_r;
            if (m == '0) m[0] = 1'b1;
         end
         CLS_PDEN, CLS_NDEN: begin
            m = man_r;
            if (m == '0) m[0] = 1'b1;
         end
         default: ;
      endcase
      // Odd class codes are the negative variants.
      op = {c[0], e, m};
   end

endmodule

// File: rtl/fp_stim_seq.sv
// fp_stim_seq
// Floating-point operand-pair stimulus sequencer with valid/ready output.
//   clk, rst            : clock, asynchronous active-high reset
//   start, mode         : begin a run in IDLE (random / sweep / single)
//   cls_a_sel, cls_b_sel: class pair for single mode
//   num_vec             : pair count for random mode
//   out_ready           : consumer accepts the presented pair
//   out_valid, a, b     : presented operand pair
//   cls_a, cls_b        : class codes of a and b (0 in random mode)
//   busy, done          : not-idle flag, one-cycle end-of-run pulse
//   vec_count           : saturating count of accepted pairs
module fp_stim_seq
   import fp_stim_pkg::*;
#(
   parameter int          EXP_W = 8,
   parameter int          MAN_W = 23,
   parameter logic [63:0] SEED  = 64'h1,
   parameter int          CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic [3:0]             cls_a_sel,
   input  logic [3:0]             cls_b_sel,
   input  logic [CNT_W-1:0]       num_vec,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [EXP_W+MAN_W:0]   a,
   output logic [EXP_W+MAN_W:0]   b,
   output logic [3:0]             cls_a,
   output logic [3:0]             cls_b,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       vec_count
);

   localparam int          W        = 1 + EXP_W + MAN_W;
   localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;
   localparam logic [3:0]  LAST_CLS = NUM_CLASSES - 4'd1;

   seq_state_t       state_q, state_d;
   logic [63:0]      lfsr_q, lfsr_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] vec_q, vec_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [3:0]       cls_a_q, cls_a_d, cls_b_q, cls_b_d;

   logic [63:0] r1, r2;
   logic [1:0]  cur_mode;
   logic [3:0]  sel_ca, sel_cb;
   logic        xfer, last_pair;
   logic [W-1:0] enc_a, enc_b;

   // Operand a consumes the first LFSR step, operand b the second.
   assign r1 = lfsr_step(lfsr_q);
   assign r2 = lfsr_step(r1);

   fp_class_encoder #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_enc_a (
      .cls (sel_ca),
      .r   (r1[W-2:0]),
      .op  (enc_a)
   );

   fp_class_encoder #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_enc_b (
      .cls (sel_cb),
      .r   (r2[W-2:0]),
      .op  (enc_b)
   );

   // Class pair of the next pair to load; kept apart from the state update
   // so the encoders sit between two independent combinational blocks.
   always_comb begin
      xfer     = out_valid_q && out_ready;
      cur_mode = (state_q == ST_IDLE) ? mode : mode_q;
      sel_ca   = '0;
      sel_cb   = '0;
      if (state_q == ST_IDLE) begin
         if (cur_mode == MODE_SINGLE) begin
            sel_ca = cls_clamp(cls_a_sel);
            sel_cb = cls_clamp(cls_b_sel);
         end
      end else if (cur_mode == MODE_SWEEP) begin
         if (cls_b_q == LAST_CLS) begin
            sel_ca = cls_a_q + 4'd1;
         end else begin
            sel_ca = cls_a_q;
            sel_cb = cls_b_q + 4'd1;
         end
      end
      case (mode_q)
         MODE_SWEEP:  last_pair = (cls_a_q == LAST_CLS) && (cls_b_q == LAST_CLS);
         MODE_SINGLE: last_pair = 1'b1;
         default:     last_pair = (rem_q == CNT_W'(1));
      endcase
   end

   always_comb begin
      logic load;
      load        = 1'b0;
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      mode_d      = mode_q;
      rem_d       = rem_q;
      vec_d       = vec_q;
      out_valid_d = out_valid_q;
      a_d         = a_q;
      b_d         = b_q;
      cls_a_d     = cls_a_q;
      cls_b_d     = cls_b_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d = mode;
               rem_d  = num_vec;
               vec_d  = '0;
               if (mode != MODE_SWEEP && mode != MODE_SINGLE && num_vec == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_GEN;
                  load    = 1'b1;
               end
            end
         end
         ST_GEN: begin
            if (xfer) begin
               if (vec_q != '1) vec_d = vec_q + CNT_W'(1);
               if (last_pair) begin
                  state_d     = ST_DONE;
                  out_valid_d = 1'b0;
               end else begin
                  rem_d = rem_q - CNT_W'(1);
                  load  = 1'b1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (load) begin
         lfsr_d      = r2;
         out_valid_d = 1'b1;
         cls_a_d     = sel_ca;
         cls_b_d     = sel_cb;
         if (cur_mode == MODE_SWEEP || cur_mode == MODE_SINGLE) begin
            a_d = enc_a;
            b_d = enc_b;
         end else begin
            a_d = r1[W-1:0];
            b_d = r2[W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= SEED_EFF;
         mode_q      <= '0;
         rem_q       <= '0;
         vec_q       <= '0;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         cls_a_q     <= '0;
         cls_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         mode_q      <= mode_d;
         rem_q       <= rem_d;
         vec_q       <= vec_d;
         out_valid_q <= out_valid_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cls_a_q     <= cls_a_d;
         cls_b_q     <= cls_b_d;
      end
   end

   assign out_valid = out_valid_q;
   assign a         = a_q;
   assign b         = b_q;
   assign cls_a     = cls_a_q;
   assign cls_b     = cls_b_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign vec_count = vec_q;

endmodule

// File: tb/tb_fp_stim_seq.sv
module tb_fp_stim_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [3:0]  cls_a_sel = 4'd0;
   logic [3:0]  cls_b_sel = 4'd0;
   logic [15:0] num_vec = 16'd0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] a, b;
   logic [3:0]  cls_a, cls_b;
   logic        busy, done;
   logic [15:0] vec_count;

   int checks = 0;
   int errors = 0;
   logic [63:0] m_lfsr = 64'd1;

   fp_stim_seq #(.EXP_W(8), .MAN_W(23), .SEED(64'h1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .cls_a_sel(cls_a_sel), .cls_b_sel(cls_b_sel), .num_vec(num_vec),
      .out_ready(out_ready), .out_valid(out_valid), .a(a), .b(b),
      .cls_a(cls_a), .cls_b(cls_b), .busy(busy), .done(done),
      .vec_count(vec_count)
   );

   always #5 clk = ~clk;

   // Reference LFSR: polynomial given by its tap list, right-shift Galois.
   function automatic logic [63:0] m_step(input logic [63:0] s);
      int taps [4] = '{64, 63, 61, 60};
      logic [63:0] mask = 64'd0;
      foreach (taps[i]) mask = mask | (64'd1 << (taps[i] - 1));
      return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
   endfunction

   // Reference operand builder in field arithmetic: sign = code parity,
   // kind = code/2 (zero, inf, sNaN, qNaN, norm, denorm).
   function automatic logic [31:0] m_enc(input int cls, input logic [63:0] r);
      int unsigned e, mn, sign, kind;
      if (cls > 11) cls = 0;
      sign = cls % 2;
      kind = cls / 2;
      e  = int'((r >> 23) % 256);
      mn = int'(r % (64'd1 << 23));
      case (kind)
         0: begin e = 0;   mn = 0; end
         1: begin e = 255; mn = 0; end
         2: begin e = 255; mn = mn % (1 << 22); if (mn == 0) mn = 1; end
         3: begin e = 255; mn = mn % (1 << 22); if (mn == 0) mn = 1; mn = mn + (1 << 22); end
         4: begin if (e == 0) e = 1; if (e == 255) e = 254; if (mn == 0) mn = 1; end
         default: begin e = 0; if (mn == 0) mn = 1; end
      endcase
      return 32'(sign * (1 << 31) + e * (1 << 23) + mn);
   endfunction

   task automatic m_next_pair(input int ca, input int cb, input bit rnd,
                              output logic [31:0] ea, output logic [31:0] eb);
      logic [63:0] r1, r2;
      r1 = m_step(m_lfsr);
      r2 = m_step(r1);
      m_lfsr = r2;
      ea = rnd ? r1[31:0] : m_enc(ca, r1);
      eb = rnd ? r2[31:0] : m_enc(cb, r2);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      checks++;
      if ({out_valid, busy, done, cls_a, cls_b, a, b, vec_count} !== 77'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0", {out_valid, busy, done, cls_a, cls_b, a, b, vec_count});
      end
      @(negedge clk) rst = 1'b0;
      m_lfsr = 64'd1;
      $display("reset released");
   endtask

   task automatic test_sweep;
      logic [31:0] ea, eb;
      @(negedge clk) begin mode = 2'b01; out_ready = 1'b1; start = 1'b1; end
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 144; k++) begin
         m_next_pair(k / 12, k % 12, 1'b0, ea, eb);
         checks++;
         if ({out_valid, done, busy, cls_a, cls_b, a, b} !== {3'b101, 4'(k / 12), 4'(k % 12), ea, eb}) begin
            errors++;
            $display("FAIL sweep_pair %0d: got v%b d%b c%0d/%0d %h %h want c%0d/%0d %h %h",
                     k, out_valid, done, cls_a, cls_b, a, b, k / 12, k % 12, ea, eb);
         end
         if (k == 0) begin
            checks++;
            if ({a, b} !== 64'h0) begin
               errors++;
               $display("FAIL sweep_pair0_zero: got %h %h want 00000000 00000000", a, b);
            end
         end
         if (k == 12) begin
            checks++;
            if ({cls_a, cls_b, a, b} !== {4'd1, 4'd0, 32'h80000000, 32'h00000000}) begin
               errors++;
               $display("FAIL sweep_pair12: got c%0d/%0d %h %h want c1/0 80000000 00000000", cls_a, cls_b, a, b);
            end
         end
         $display("sweep pair %0d cls %0d/%0d a=%h b=%h", k, cls_a, cls_b, a, b);
         @(negedge clk);
      end
      checks++;
      if ({done, out_valid, vec_count} !== {2'b10, 16'd144}) begin
         errors++;
         $display("FAIL sweep_done: got d%b v%b cnt %0d want d1 v0 cnt 144", done, out_valid, vec_count);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, vec_count} !== {2'b00, 16'd144}) begin
         errors++;
         $display("FAIL sweep_idle: got d%b busy%b cnt %0d want d0 busy0 cnt 144", done, busy, vec_count);
      end
   endtask

   task automatic test_single;
      logic [31:0] ea, eb;
      logic        b_ok;
      @(negedge clk) begin mode = 2'b10; cls_a_sel = 4'd2; cls_b_sel = 4'd4; out_ready = 1'b1; start = 1'b1; end
      @(negedge clk) begin start = 1'b0; cls_a_sel = 4'($urandom); cls_b_sel = 4'($urandom); mode = 2'($urandom); end
      m_next_pair(2, 4, 1'b0, ea, eb);
      checks++;
      if ({out_valid, cls_a, cls_b, a, b} !== {1'b1, 4'd2, 4'd4, ea, eb}) begin
         errors++;
         $display("FAIL single_pair: got v%b c%0d/%0d %h %h want v1 c2/4 %h %h", out_valid, cls_a, cls_b, a, b, ea, eb);
      end
      b_ok = (b[30:23] == 8'hFF) && !b[22] && (b[21:0] != 22'd0);
      checks++;
      if ({a, b_ok} !== {32'h7F800000, 1'b1}) begin
         errors++;
         $display("FAIL single_fields: got a=%h b=%h want a=7f800000 b=sNaN", a, b);
      end
      $display("single pair cls %0d/%0d a=%h b=%h", cls_a, cls_b, a, b);
      @(negedge clk);
      checks++;
      if ({done, out_valid, vec_count} !== {2'b10, 16'd1}) begin
         errors++;
         $display("FAIL single_done: got d%b v%b cnt %0d want d1 v0 cnt 1", done, out_valid, vec_count);
      end
      @(negedge clk);
   endtask

   task automatic test_random_stall;
      logic [31:0] ea, eb;
      @(negedge clk) begin mode = 2'b00; num_vec = 16'd8; out_ready = 1'b1; start = 1'b1; end
      @(negedge clk) start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         m_next_pair(0, 0, 1'b1, ea, eb);
         checks++;
         if ({out_valid, cls_a, cls_b, a, b} !== {9'h100, ea, eb}) begin
            errors++;
            $display("FAIL random_pair %0d: got v%b c%0d/%0d %h %h want v1 c0/0 %h %h", k, out_valid, cls_a, cls_b, a, b, ea, eb);
         end
         if (k == 3) begin
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               start = (s == 0);
               mode  = 2'b01;
               checks++;
               if ({out_valid, cls_a, cls_b, a, b} !== {9'h100, ea, eb}) begin
                  errors++;
                  $display("FAIL stall_hold %0d: got v%b %h %h want v1 %h %h", s, out_valid, a, b, ea, eb);
               end
            end
            start = 1'b0;
            out_ready = 1'b1;
         end
         $display("random pair %0d a=%h b=%h", k, a, b);
         @(negedge clk);
      end
      checks++;
      if ({done, out_valid, vec_count} !== {2'b10, 16'd8}) begin
         errors++;
         $display("FAIL random_done: got d%b v%b cnt %0d want d1 v0 cnt 8", done, out_valid, vec_count);
      end
      @(negedge clk);
   endtask

   task automatic test_random_ready;
      logic [31:0] ea, eb;
      int n, got, cycles;
      bit r;
      for (int run = 0; run < 3; run++) begin
         n = $urandom_range(1, 24);
         @(negedge clk) begin mode = 2'b00; num_vec = 16'(n); start = 1'b1; out_ready = 1'b0; end
         @(negedge clk) start = 1'b0;
         got = 0;
         cycles = 0;
         m_next_pair(0, 0, 1'b1, ea, eb);
         while (got < n && cycles < 500) begin
            checks++;
            if ({out_valid, done, a, b} !== {2'b10, ea, eb}) begin
               errors++;
               $display("FAIL rready_pair %0d.%0d: got v%b d%b %h %h want v1 d0 %h %h", run, got, out_valid, done, a, b, ea, eb);
            end
            r = 1'($urandom);
            out_ready = r;
            @(negedge clk);
            cycles++;
            if (r) begin
               $display("rready run %0d pair %0d a=%h b=%h", run, got, ea, eb);
               got++;
               if (got < n) m_next_pair(0, 0, 1'b1, ea, eb);
            end
         end
         checks++;
         if ({cycles < 500, done, out_valid, vec_count} !== {3'b110, 16'(n)}) begin
            errors++;
            $display("FAIL rready_done %0d: got d%b v%b cnt %0d cycles %0d want d1 v0 cnt %0d", run, done, out_valid, vec_count, cycles, n);
         end
         out_ready = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_zero;
      @(negedge clk) begin mode = 2'b00; num_vec = 16'd0; start = 1'b1; end
      @(negedge clk) start = 1'b0;
      checks++;
      if ({done, out_valid, busy, vec_count} !== {3'b101, 16'd0}) begin
         errors++;
         $display("FAIL zero_done: got d%b v%b busy%b cnt %0d want d1 v0 busy1 cnt 0", done, out_valid, busy, vec_count);
      end
      @(negedge clk);
      checks++;
      if ({done, out_valid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL zero_idle: got d%b v%b busy%b want 000", done, out_valid, busy);
      end
      $display("zero-length run complete");
   endtask

   task automatic test_reset_mid;
      logic [31:0] ea, eb;
      @(negedge clk) begin mode = 2'b01; out_ready = 1'b1; start = 1'b1; end
      @(negedge clk) start = 1'b0;
      for (int k = 0; k <= 50; k++) begin
         m_next_pair(k / 12, k % 12, 1'b0, ea, eb);
         checks++;
         if ({out_valid, cls_a, cls_b, a, b} !== {1'b1, 4'(k / 12), 4'(k % 12), ea, eb}) begin
            errors++;
            $display("FAIL midrst_pair %0d: got c%0d/%0d %h %h want c%0d/%0d %h %h", k, cls_a, cls_b, a, b, k / 12, k % 12, ea, eb);
         end
         $display("midrst pair %0d cls %0d/%0d a=%h b=%h", k, cls_a, cls_b, a, b);
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, done, cls_a, cls_b, a, b, vec_count} !== 77'd0) begin
         errors++;
         $display("FAIL midrst_async: got %h want 0", {out_valid, busy, done, cls_a, cls_b, a, b, vec_count});
      end
      @(negedge clk) rst = 1'b0;
      m_lfsr = 64'd1;
      @(negedge clk);
      checks++;
      if ({done, busy, out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_nodone: got d%b busy%b v%b want 000", done, busy, out_valid);
      end
      $display("mid-run reset applied");
   endtask

   task automatic test_sweep_repeat;
      logic [31:0] ea, eb;
      bit prop_ok;
      for (int run = 0; run < 20; run++) begin
         @(negedge clk) begin mode = 2'b01; out_ready = 1'b1; start = 1'b1; end
         @(negedge clk) start = 1'b0;
         for (int k = 0; k < 144; k++) begin
            m_next_pair(k / 12, k % 12, 1'b0, ea, eb);
            checks++;
            if ({out_valid, cls_a, cls_b, a, b} !== {1'b1, 4'(k / 12), 4'(k % 12), ea, eb}) begin
               errors++;
               $display("FAIL rep_pair %0d.%0d: got c%0d/%0d %h %h want %h %h", run, k, cls_a, cls_b, a, b, ea, eb);
            end
            prop_ok = 1'b1;
            if ((cls_a == 8 || cls_a == 9) && (a[30:23] == 8'h00 || a[30:23] == 8'hFF)) prop_ok = 1'b0;
            if ((cls_b == 8 || cls_b == 9) && (b[30:23] == 8'h00 || b[30:23] == 8'hFF)) prop_ok = 1'b0;
            if (cls_a inside {[4:7], 10, 11} && a[22:0] == 23'd0) prop_ok = 1'b0;
            if (cls_b inside {[4:7], 10, 11} && b[22:0] == 23'd0) prop_ok = 1'b0;
            checks++;
            if (prop_ok !== 1'b1) begin
               errors++;
               $display("FAIL rep_class_prop %0d.%0d: a=%h b=%h violate class form", run, k, a, b);
            end
            $display("rep %0d pair %0d cls %0d/%0d a=%h b=%h", run, k, cls_a, cls_b, a, b);
            @(negedge clk);
         end
         checks++;
         if ({done, vec_count} !== {1'b1, 16'd144}) begin
            errors++;
            $display("FAIL rep_done %0d: got d%b cnt %0d want d1 cnt 144", run, done, vec_count);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_sweep;
      test_single;
      test_random_stall;
      test_random_ready;
      test_zero;
      test_random_stall;
      test_reset_mid;
      test_sweep;
      test_sweep_repeat;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
